alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Execute-stage front end that produces the `Operation`/`SrcA`/`SrcB` stream consumed by the 4-bit-opcode ALU. It decodes a 32-bit RV32I instruction plus register-file operands and PC into the ALU opcode and operands, and registers the result through a two-entry skid buffer. The buffer uses valid/ready handshakes on both sides and a flush input for branch redirects. It sits between the register-read (ID) stage and the ALU in the EX stage.

## Interface
- `DATA_WIDTH`, 32: operand and PC width.
- `OPCODE_LENGTH`, 4: ALU operation code width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: ID-side payload valid.
- `in_ready` out 1: registered; stage can accept a payload this cycle.
- `instr` in 32: instruction word.
- `pc` in DATA_WIDTH: instruction address.
- `rs1_data`, `rs2_data` in DATA_WIDTH: register operands.
- `flush` in 1: discard all buffered and incoming payloads.
- `out_valid` out 1: EX-side payload valid.
- `out_ready` in 1: ALU/EX consumer accepts the payload.
- `SrcA`, `SrcB` out DATA_WIDTH: ALU operands.
- `Operation` out OPCODE_LENGTH: ALU opcode.
- `is_branch` out 1: payload is a conditional branch compare.
- `illegal` out 1: instruction is not supported by this stage.
- `pc_out` out DATA_WIDTH, `rd_out` out 5: passthrough of `pc` and `instr[11:7]`.

## Operation
- ALU opcodes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, EQ 1000, GE 1001, NE 1010, LT 1100.
- R-type (0110011), with SrcA=rs1 and SrcB=rs2:
  - f3 000 selects ADD if f7=0000000, SUB if f7=0100000.
  - f3 111 AND, 110 OR, 100 XOR, 001 SLL.
  - f3 101 selects SRL if f7=0000000, SRA if f7=0100000.
  - f3 010 (SLT) selects LT.
  - f3 011 (SLTU) and any other f7 are illegal.
- I-ALU (0010011), with SrcA=rs1 and SrcB=sign-extended imm[11:0]:
  - ADDI, ANDI, ORI and XORI map to the matching opcode; SLTI maps to LT.
  - SLLI, SRLI and SRAI set SrcB = zero-extended `instr[24:20]`; f7 rules are the same as R-type.
  - SLTIU is illegal.
- Load (0000011) and JALR (1100111): ADD, SrcA=rs1, SrcB=sign-extended I-imm.
- Store (0100011): ADD, SrcA=rs1, SrcB=sign-extended S-imm (`instr[31:25]`,`instr[11:7]`).
- Branch (1100011), with SrcA=rs1, SrcB=rs2 and is_branch=1:
  - f3 000 EQ, 001 NE, 100 LT, 101 GE.
  - Other f3 values are illegal.
- LUI (0110111): ADD, SrcA=0, SrcB={instr[31:12],12'b0}.
- AUIPC (0010111): ADD, SrcA=pc, SrcB={instr[31:12],12'b0}.
- JAL (1101111): ADD, SrcA=pc, SrcB=4 (link address).
- Any other opcode is illegal. An illegal payload still flows through the buffer with illegal=1, Operation=0000, SrcA=SrcB=0 and is_branch=0.
- Skid buffer:
  - Registers: main, skid, and state EMPTY/ONE/FULL.
  - `accept = in_valid & in_ready & !flush & !reset`; `drain = out_valid & out_ready`.
  - EMPTY: accept → ONE (main ← decoded input).
  - ONE: accept&drain → ONE (main ← new); accept&!drain → FULL (skid ← new); !accept&drain → EMPTY; otherwise hold.
  - FULL: drain → ONE (main ← skid); otherwise hold. No accept is possible.
  - `flush` → EMPTY next cycle, regardless of drain or in_valid; the concurrent input is dropped.
- `out_valid = (state != EMPTY)`; outputs always come from main. Payload is stable while out_valid & !out_ready.
- `in_ready` is a register: next value = (next_state != FULL). It never depends combinationally on out_ready.
- Reset: state EMPTY, in_ready=1 the cycle after reset deasserts. out_valid=0, all data outputs 0, Operation=0000, is_branch=0, illegal=0. Reset mid-operation discards all buffered entries.

## Timing
- Latency is 1 cycle: payload accepted at edge N is visible with out_valid=1 after edge N (if main was empty or draining).
- Throughput is 1 payload/cycle with out_ready held high.
- After out_ready drops, at most one more payload is accepted (into skid); in_ready falls the cycle after entering FULL.
- Ordering is strictly FIFO; no payload is lost or duplicated.
- Priority: reset > flush > drain/accept.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, Operation=0010, SrcA=5, SrcB=7, rd_out=3, illegal=0.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 → Operation=0111, SrcB=3; LUI x1,0x12345 (0x123450B7) → Operation=0010, SrcA=0, SrcB=0x12345000.
- BGE x1,x2 (f3=101), rs1=0xFFFFFFFF, rs2=1 → Operation=1001, SrcA=0xFFFFFFFF, SrcB=1, is_branch=1. SLTU (R-type f3=011) → illegal=1, Operation=0000, SrcA=SrcB=0.
- Backpressure:
  - Stimulus: out_ready=0, three back-to-back valid ADDIs with imm 1, 2, 3.
  - Required: imm 1 lands in main, imm 2 in skid, in_ready=0 the following cycle, imm 3 held by the source.
  - Raise out_ready → SrcB sequence 1, 2, 3 on consecutive cycles, no gaps or duplicates.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle input is never output.
- Reset asserted while FULL → next cycle out_valid=0 and all outputs 0. First payload after reset releases appears 1 cycle after accept.

Source files
------------

// File: rtl/alu_issue_stage.sv
// EX-stage front end: decodes an RV32I instruction into ALU opcode/operands and
// hands the result to the ALU through a two-entry valid/ready skid buffer.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [DATA_WIDTH-1:0]    pc,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     is_branch,
  output logic                     illegal,
  output logic [DATA_WIDTH-1:0]    pc_out,
  output logic [4:0]               rd_out
);

  // state  | meaning
  // EMPTY  | nothing buffered, out_valid low
  // ONE    | payload in main only
  // FULL   | main and skid both hold payloads, input stalled
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    src_a;
    logic [DATA_WIDTH-1:0]    src_b;
    logic [OPCODE_LENGTH-1:0] op;
    logic                     br;
    logic                     ill;
    logic [DATA_WIDTH-1:0]    pc;
    logic [4:0]               rd;
  } payload_t;

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(4'b1100);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7_zero;
  logic       f7_alt;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] shamt;
  logic unused_rs_fields;

  assign opcode  = instr[6:0];
  assign f3      = instr[14:12];
  assign f7_zero = (instr[31:25] == 7'b0000000);
  assign f7_alt  = (instr[31:25] == 7'b0100000);
  assign imm_i   = DATA_WIDTH'($signed(instr[31:20]));
  assign imm_s   = DATA_WIDTH'($signed({instr[31:25], instr[11:7]}));
  assign imm_u   = DATA_WIDTH'({instr[31:12], 12'b0});
  assign shamt   = DATA_WIDTH'(instr[24:20]);
  // Register specifiers were already consumed by the register-read stage.
  assign unused_rs_fields = ^instr[24:15];

  payload_t dec;

  always_comb begin
    dec       = '0;
    dec.pc    = pc;
    dec.rd    = instr[11:7];
    dec.op    = OP_AND;
    case (opcode)
      OPC_R: begin
        dec.src_a = rs1_data;
        dec.src_b = rs2_data;
        dec.ill   = !(f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
        case (f3)
          3'b000:  dec.op = f7_alt ? OP_SUB : OP_ADD;
          3'b001:  dec.op = OP_SLL;
          3'b010:  dec.op = OP_LT;
          3'b100:  dec.op = OP_XOR;
          3'b101:  dec.op = f7_alt ? OP_SRA : OP_SRL;
          3'b110:  dec.op = OP_OR;
          3'b111:  dec.op = OP_AND;
          default: dec.ill = 1'b1;
        endcase
      end
      OPC_I: begin
        dec.src_a = rs1_data;
        dec.src_b = imm_i;
        case (f3)
          3'b000: dec.op = OP_ADD;
          3'b010: dec.op = OP_LT;
          3'b100: dec.op = OP_XOR;
          3'b110: dec.op = OP_OR;
          3'b111: dec.op = OP_AND;
          3'b001: begin
            dec.op    = OP_SLL;
            dec.src_b = shamt;
            dec.ill   = !f7_zero;
          end
          3'b101: begin
            dec.op    = f7_alt ? OP_SRA : OP_SRL;
            dec.src_b = shamt;
            dec.ill   = !(f7_zero || f7_alt);
          end
          default: dec.ill = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_JALR: begin
        dec.op    = OP_ADD;
        dec.src_a = rs1_data;
        dec.src_b = imm_i;
      end
      OPC_STORE: begin
        dec.op    = OP_ADD;
        dec.src_a = rs1_data;
        dec.src_b = imm_s;
      end
      OPC_BRANCH: begin
        dec.src_a = rs1_data;
        dec.src_b = rs2_data;
        dec.br    = 1'b1;
        case (f3)
          3'b000:  dec.op = OP_EQ;
          3'b001:  dec.op = OP_NE;
          3'b100:  dec.op = OP_LT;
          3'b101:  dec.op = OP_GE;
          default: dec.ill = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.op    = OP_ADD;
        dec.src_b = imm_u;
      end
      OPC_AUIPC: begin
        dec.op    = OP_ADD;
        dec.src_a = pc;
        dec.src_b = imm_u;
      end
      OPC_JAL: begin
        dec.op    = OP_ADD;
        dec.src_a = pc;
        dec.src_b = DATA_WIDTH'(4);
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal payloads still flow, but carry no operands or branch intent.
    if (dec.ill) begin
      dec.op    = OP_AND;
      dec.src_a = '0;
      dec.src_b = '0;
      dec.br    = 1'b0;
    end
  end

  state_t   state_q;
  payload_t main_q;
  payload_t skid_q;
  logic     in_ready_q;
  logic     accept;
  logic     drain;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q && !flush && !reset;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= dec;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q  <= dec;
            state_q <= FULL;
          end else if (drain) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
      // in_ready mirrors "next state is not FULL" so it never sees out_ready combinationally.
      in_ready_q <= !(((state_q == ONE) && accept && !drain) ||
                      ((state_q == FULL) && !drain));
    end
  end

  assign SrcA      = main_q.src_a;
  assign SrcB      = main_q.src_b;
  assign Operation = main_q.op;
  assign is_branch = main_q.br;
  assign illegal   = main_q.ill;
  assign pc_out    = main_q.pc;
  assign rd_out    = main_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure, flush and reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  Operation;
  logic        is_branch;
  logic        illegal;
  logic [31:0] pc_out;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .is_branch(is_branch),
    .illegal(illegal), .pc_out(pc_out), .rd_out(rd_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic br, input logic ill);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".op"},    32'(Operation), 32'(op));
    chk({tag, ".srca"},  SrcA, a);
    chk({tag, ".srcb"},  SrcB, b);
    chk({tag, ".br"},    32'(is_branch), 32'(br));
    chk({tag, ".ill"},   32'(illegal), 32'(ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p);
    in_valid = 1'b1;
    instr    = i;
    rs1_data = a;
    rs2_data = b;
    pc       = p;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = '0; pc = '0;
    rs1_data = '0; rs2_data = '0; flush = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.srca", SrcA, 32'd0);
    chk("rst.op", 32'(Operation), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst.ready", 32'(in_ready), 32'd1);
    chk("post_rst.valid", 32'(out_valid), 32'd0);

    // Decode vectors streamed back-to-back with out_ready high.
    out_ready = 1'b1;
    drive(32'h002081B3, 32'd5, 32'd7, 32'h0000_0100);
    tick();
    chk_out("add", 4'b0010, 32'd5, 32'd7, 1'b0, 1'b0);
    chk("add.rd", 32'(rd_out), 32'd3);
    chk("add.pc", pc_out, 32'h0000_0100);
    chk("add.ready", 32'(in_ready), 32'd1);

    drive(32'h40335293, 32'h8000_0000, 32'd0, 32'h0000_0104);
    tick();
    chk_out("srai", 4'b0111, 32'h8000_0000, 32'd3, 1'b0, 1'b0);
    chk("srai.rd", 32'(rd_out), 32'd5);

    drive(32'h123450B7, 32'hDEAD_BEEF, 32'd0, 32'h0000_0108);
    tick();
    chk_out("lui", 4'b0010, 32'd0, 32'h1234_5000, 1'b0, 1'b0);

    drive(32'h0020D063, 32'hFFFF_FFFF, 32'd1, 32'h0000_010C);
    tick();
    chk_out("bge", 4'b1001, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);

    drive(32'h0020B1B3, 32'd5, 32'd7, 32'h0000_0110);
    tick();
    chk_out("sltu", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1);

    drive(32'h402081B3, 32'd9, 32'd4, 32'h0000_0114);
    tick();
    chk_out("sub", 4'b0110, 32'd9, 32'd4, 1'b0, 1'b0);

    drive(32'hFE20AE23, 32'h0000_1000, 32'd3, 32'h0000_0118);
    tick();
    chk_out("sw", 4'b0010, 32'h0000_1000, 32'hFFFF_FFFC, 1'b0, 1'b0);

    drive(32'h00001117, 32'd0, 32'd0, 32'h0000_011C);
    tick();
    chk_out("auipc", 4'b0010, 32'h0000_011C, 32'h0000_1000, 1'b0, 1'b0);

    drive(32'h0000006F, 32'd0, 32'd0, 32'h0000_0120);
    tick();
    chk_out("jal", 4'b0010, 32'h0000_0120, 32'd4, 1'b0, 1'b0);

    drive(32'h40109093, 32'd1, 32'd0, 32'h0000_0124);
    tick();
    chk_out("slli_badf7", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1);

    drive(32'h0000007F, 32'd1, 32'd2, 32'h0000_0128);
    tick();
    chk_out("bad_opc", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1);

    in_valid = 1'b0;
    tick();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure: ADDI 1/2/3 with the consumer stalled.
    out_ready = 1'b0;
    drive(32'h00100093, 32'd0, 32'd0, 32'h0000_0200);
    tick();
    chk("bp1.valid", 32'(out_valid), 32'd1);
    chk("bp1.srcb", SrcB, 32'd1);
    chk("bp1.ready", 32'(in_ready), 32'd1);
    drive(32'h00200093, 32'd0, 32'd0, 32'h0000_0204);
    tick();
    chk("bp2.ready", 32'(in_ready), 32'd0);
    chk("bp2.srcb", SrcB, 32'd1);
    drive(32'h00300093, 32'd0, 32'd0, 32'h0000_0208);
    tick();
    chk("bp3.ready", 32'(in_ready), 32'd0);
    chk("bp3.srcb", SrcB, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bpseq2.valid", 32'(out_valid), 32'd1);
    chk("bpseq2.srcb", SrcB, 32'd2);
    chk("bpseq2.ready", 32'(in_ready), 32'd1);
    tick();
    chk("bpseq3.valid", 32'(out_valid), 32'd1);
    chk("bpseq3.srcb", SrcB, 32'd3);
    in_valid = 1'b0;
    tick();
    chk("bpend.valid", 32'(out_valid), 32'd0);

    // Flush while FULL with a new payload offered.
    out_ready = 1'b0;
    drive(32'h00100093, 32'd0, 32'd0, 32'h0000_0300);
    tick();
    drive(32'h00200093, 32'd0, 32'd0, 32'h0000_0304);
    tick();
    chk("fl_full.ready", 32'(in_ready), 32'd0);
    drive(32'h00900093, 32'd0, 32'd0, 32'h0000_0308);
    flush = 1'b1;
    tick();
    chk("flush.valid", 32'(out_valid), 32'd0);
    chk("flush.ready", 32'(in_ready), 32'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("flush_after.valid", 32'(out_valid), 32'd0);

    // Flush in ONE while the source offers a payload: that payload is dropped.
    drive(32'h00400093, 32'd0, 32'd0, 32'h0000_0310);
    out_ready = 1'b0;
    tick();
    chk("fl_one.srcb", SrcB, 32'd4);
    drive(32'h00600093, 32'd0, 32'd0, 32'h0000_0314);
    flush = 1'b1;
    tick();
    chk("fl_one.valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_one_after.valid", 32'(out_valid), 32'd0);
    drive(32'h00500093, 32'd0, 32'd0, 32'h0000_0318);
    tick();
    chk("post_flush.valid", 32'(out_valid), 32'd1);
    chk("post_flush.srcb", SrcB, 32'd5);
    in_valid = 1'b0;
    tick();

    // Reset while FULL.
    out_ready = 1'b0;
    drive(32'h00100093, 32'h55, 32'd0, 32'h0000_0400);
    tick();
    drive(32'h00200093, 32'h66, 32'd0, 32'h0000_0404);
    tick();
    chk("rfull.ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("rfull.valid", 32'(out_valid), 32'd0);
    chk("rfull.srca", SrcA, 32'd0);
    chk("rfull.srcb", SrcB, 32'd0);
    chk("rfull.op", 32'(Operation), 32'd0);
    chk("rfull.pc", pc_out, 32'd0);
    chk("rfull.rd", 32'(rd_out), 32'd0);
    chk("rfull.ill", 32'(illegal), 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rrel.valid", 32'(out_valid), 32'd0);
    chk("rrel.ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    drive(32'h002081B3, 32'd9, 32'd1, 32'h0000_0500);
    tick();
    chk_out("rrel_add", 4'b0010, 32'd9, 32'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
